// File: rtl/shifter_barrel_pipelined.sv
// ---------------------------------------------------------------------------
// shifter_barrel_pipelined
//
// Pipelined barrel shifter for SLL, SRL, SRA, ROL and ROR.
//
// The datapath is a single right shifter built from nb_bits_shift fixed
// stages; stage k shifts right by 2**k when bit k of the shift amount is set.
// Left modes are obtained by bit-reversing the operand before the first
// stage and the result after the last stage. Pipeline registers are placed
// after every group of stages_per_reg stages, so the latency is
// L = ceil(nb_bits_shift / stages_per_reg) cycles and the last slice
// register is the output register.
//
// A single global stall freezes every slice while a valid result is waiting
// for ready_i; bubbles travel through the pipe as valid = 0.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n_i        synchronous active-low reset
//   valid_i        operand valid
//   ready_o        block accepts an operand this cycle
//   data_i         operand
//   shift_value_i  shift amount
//   op_i           000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   valid_o        result valid
//   ready_i        downstream accepts the result
//   data_o         result
//   op_err_o       result came from an illegal op_i (operand passed unshifted)
// ---------------------------------------------------------------------------
module shifter_barrel_pipelined #(
    parameter int nb_bits_data   = 32,
    parameter int nb_bits_shift  = 5,
    parameter int stages_per_reg = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [nb_bits_data-1:0]  data_i,
    input  logic [nb_bits_shift-1:0] shift_value_i,
    input  logic [2:0]               op_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [nb_bits_data-1:0]  data_o,
    output logic                     op_err_o
);

    localparam int W = nb_bits_data;
    localparam int S = nb_bits_shift;
    localparam int L = (S + stages_per_reg - 1) / stages_per_reg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // Mirror a word end to end; turns the right shifter into a left shifter.
    function automatic logic [W-1:0] bit_reverse(input logic [W-1:0] x);
        logic [W-1:0] y;
        for (int b = 0; b < W; b++) begin
            y[b] = x[W-1-b];
        end
        return y;
    endfunction

    // One fixed right-shift stage by amt bits, circular or filled with fill.
    function automatic logic [W-1:0] shift_right_fixed(
        input logic [W-1:0] x,
        input int           amt,
        input logic         rot,
        input logic         fill
    );
        logic [W-1:0] y;
        for (int b = 0; b < W; b++) begin
            if (b + amt < W) begin
                y[b] = x[b + amt];
            end else if (rot) begin
                y[b] = x[b + amt - W];
            end else begin
                y[b] = fill;
            end
        end
        return y;
    endfunction

    // Decoded operand entering the first slice.
    logic [W-1:0] in_data_s;
    logic [S-1:0] in_shamt_s;
    logic         in_rot_s;
    logic         in_fill_s;
    logic         in_left_s;
    logic         in_err_s;

    // Slice registers; index L-1 is the output register.
    logic [W-1:0] data_q  [L];
    logic [S-1:0] shamt_q [L];
    logic         rot_q   [L];
    logic         fill_q  [L];
    logic         left_q  [L];
    logic         err_q   [L];
    logic         valid_q [L];

    // Slice inputs (next-state of each slice) and the shifted data.
    logic [W-1:0] stage_in_s [L];
    logic [W-1:0] data_d     [L];
    logic [S-1:0] shamt_d    [L];
    logic         rot_d      [L];
    logic         fill_d     [L];
    logic         left_d     [L];
    logic         err_d      [L];
    logic         valid_d    [L];

    logic [W-1:0] work_s;
    logic         advance_s;

    // Global stall: everything moves unless a result is waiting on ready_i.
    assign advance_s = ready_i | ~valid_q[L-1];
    assign ready_o   = advance_s;
    assign valid_o   = valid_q[L-1];
    assign data_o    = data_q[L-1];
    assign op_err_o  = err_q[L-1];

    // Decode op_i into shifter controls; illegal ops force a zero shift.
    always_comb begin
        in_rot_s  = 1'b0;
        in_fill_s = 1'b0;
        in_left_s = 1'b0;
        in_err_s  = 1'b0;
        case (op_i)
            OP_SLL: begin
                in_left_s = 1'b1;
            end
            OP_SRL: begin
                in_fill_s = 1'b0;
            end
            OP_SRA: begin
                in_fill_s = data_i[W-1];
            end
            OP_ROL: begin
                in_left_s = 1'b1;
                in_rot_s  = 1'b1;
            end
            OP_ROR: begin
                in_rot_s  = 1'b1;
            end
            default: begin
                in_err_s  = 1'b1;
            end
        endcase
        in_shamt_s = in_err_s  ? '0                    : shift_value_i;
        in_data_s  = in_left_s ? bit_reverse(data_i)   : data_i;
    end

    // Route each slice's source: the decoded operand or the previous slice.
    always_comb begin
        stage_in_s[0] = in_data_s;
        shamt_d[0]    = in_shamt_s;
        rot_d[0]      = in_rot_s;
        fill_d[0]     = in_fill_s;
        left_d[0]     = in_left_s;
        err_d[0]      = in_err_s;
        valid_d[0]    = valid_i;
        for (int j = 1; j < L; j++) begin
            stage_in_s[j] = data_q[j-1];
            shamt_d[j]    = shamt_q[j-1];
            rot_d[j]      = rot_q[j-1];
            fill_d[j]     = fill_q[j-1];
            left_d[j]     = left_q[j-1];
            err_d[j]      = err_q[j-1];
            valid_d[j]    = valid_q[j-1];
        end
    end

    // Apply the fixed stages owned by each slice; undo the reversal at the end.
    always_comb begin
        work_s = '0;
        for (int j = 0; j < L; j++) begin
            work_s = stage_in_s[j];
            for (int k = 0; k < S; k++) begin
                work_s = (((k / stages_per_reg) == j) && shamt_d[j][k])
                       ? shift_right_fixed(work_s, 1 << k, rot_d[j], fill_d[j])
                       : work_s;
            end
            data_d[j] = ((j == L - 1) && left_d[j]) ? bit_reverse(work_s) : work_s;
        end
    end

    // Slice registers: reset drops every in-flight item, stall holds all.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < L; j++) begin
                valid_q[j] <= 1'b0;
            end
            data_q[L-1] <= '0;
            err_q[L-1]  <= 1'b0;
        end else if (advance_s) begin
            for (int j = 0; j < L; j++) begin
                data_q[j]  <= data_d[j];
                shamt_q[j] <= shamt_d[j];
                rot_q[j]   <= rot_d[j];
                fill_q[j]  <= fill_d[j];
                left_q[j]  <= left_d[j];
                err_q[j]   <= err_d[j];
                valid_q[j] <= valid_d[j];
            end
        end
    end

endmodule

// File: tb/tb_shifter_barrel_pipelined.sv
module tb_shifter_barrel_pipelined;

    localparam int LAT_A = 3;
    localparam int LAT_B = 4;
    localparam int NVEC  = 25;

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROL = 3'b011;
    localparam logic [2:0] ROR = 3'b100;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  sh;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default 32-bit configuration
    logic        a_rst_n, a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_op_err_o;
    logic [31:0] a_data_i, a_data_o;
    logic [4:0]  a_shift;
    logic [2:0]  a_op;

    // DUT B: 16-bit, one stage per register
    logic        b_rst_n, b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_op_err_o;
    logic [15:0] b_data_i, b_data_o;
    logic [3:0]  b_shift;
    logic [2:0]  b_op;

    shifter_barrel_pipelined u_dut_a (
        .clk_i(clk), .rst_n_i(a_rst_n), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .data_i(a_data_i), .shift_value_i(a_shift), .op_i(a_op),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .op_err_o(a_op_err_o)
    );

    shifter_barrel_pipelined #(
        .nb_bits_data(16), .nb_bits_shift(4), .stages_per_reg(1)
    ) u_dut_b (
        .clk_i(clk), .rst_n_i(b_rst_n), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .data_i(b_data_i), .shift_value_i(b_shift), .op_i(b_op),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .op_err_o(b_op_err_o)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent 16-bit reference: returns {err, result}
    function automatic logic [16:0] ref16(input logic [2:0] op, input logic [15:0] d, input logic [3:0] sh);
        logic [15:0] r;
        logic [4:0]  inv;
        inv = 5'd16 - {1'b0, sh};
        case (op)
            3'd0:    r = d << sh;
            3'd1:    r = d >> sh;
            3'd2:    r = $signed(d) >>> sh;
            3'd3:    r = (d << sh) | (d >> inv);
            3'd4:    r = (d >> sh) | (d << inv);
            default: return {1'b1, d};
        endcase
        return {1'b0, r};
    endfunction

    // Issue vec[first .. first+count-1] back to back on DUT A with ready_i = 1
    task automatic run_vectors(input int first, input int count);
        int rx;
        rx = 0;
        a_ready_i = 1'b1;
        for (int n = 0; n < count + LAT_A + 1; n++) begin
            if (n < count) begin
                a_valid_i = 1'b1;
                a_op      = vec[first + n].op;
                a_data_i  = vec[first + n].data;
                a_shift   = vec[first + n].sh;
            end else begin
                a_valid_i = 1'b0;
            end
            tick();
            if (a_valid_o) begin
                if (rx < count) begin
                    check($sformatf("A latency v%0d", first + rx), 32'(n), 32'(rx + LAT_A - 1));
                    check($sformatf("A data v%0d", first + rx), a_data_o, vec[first + rx].exp);
                    check($sformatf("A err v%0d", first + rx), 32'(a_op_err_o), 32'(vec[first + rx].err));
                end else begin
                    check("A extra result", 32'(rx), 32'(count - 1));
                end
                rx++;
            end
        end
        check("A result count", 32'(rx), 32'(count));
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh);
        a_valid_i = 1'b1;
        a_op      = op;
        a_data_i  = d;
        a_shift   = sh;
    endtask

    initial begin
        int          pulses;
        int          rx;
        int          nb;
        logic [16:0] e;
        logic [2:0]  q_op [$];
        logic [15:0] q_d  [$];
        logic [3:0]  q_sh [$];
        logic [15:0] bd [4];
        logic [3:0]  bs [4];

        vec[0]  = '{SLL,    32'h000000F0,  5'd4, 32'h00000F00, 1'b0};
        vec[1]  = '{SRL,    32'hF0000000,  5'd4, 32'h0F000000, 1'b0};
        vec[2]  = '{SRA,    32'hF0000000,  5'd4, 32'hFF000000, 1'b0};
        vec[3]  = '{ROL,    32'h80000001,  5'd1, 32'h00000003, 1'b0};
        vec[4]  = '{ROR,    32'h80000001,  5'd1, 32'hC0000000, 1'b0};
        vec[5]  = '{SLL,    32'h00000001, 5'd31, 32'h80000000, 1'b0};
        vec[6]  = '{SRA,    32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0};
        vec[7]  = '{SRL,    32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b0};
        vec[8]  = '{ROR,    32'h00000001, 5'd31, 32'h00000002, 1'b0};
        vec[9]  = '{ROL,    32'h00000001, 5'd31, 32'h80000000, 1'b0};
        vec[10] = '{SRA,    32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b0};
        vec[11] = '{SLL,    32'hDEADBEEF,  5'd0, 32'hDEADBEEF, 1'b0};
        vec[12] = '{SRL,    32'hDEADBEEF,  5'd0, 32'hDEADBEEF, 1'b0};
        vec[13] = '{SRA,    32'hDEADBEEF,  5'd0, 32'hDEADBEEF, 1'b0};
        vec[14] = '{ROL,    32'hDEADBEEF,  5'd0, 32'hDEADBEEF, 1'b0};
        vec[15] = '{ROR,    32'hDEADBEEF,  5'd0, 32'hDEADBEEF, 1'b0};
        vec[16] = '{ROL,    32'h12345678,  5'd8, 32'h34567812, 1'b0};
        vec[17] = '{ROR,    32'h12345678, 5'd12, 32'h67812345, 1'b0};
        vec[18] = '{SRA,    32'h7000000F,  5'd3, 32'h0E000001, 1'b0};
        vec[19] = '{SLL,    32'h0000ABCD, 5'd16, 32'hABCD0000, 1'b0};
        vec[20] = '{3'b110, 32'h12345678,  5'd7, 32'h12345678, 1'b1};
        vec[21] = '{SRL,    32'h00000100,  5'd8, 32'h00000001, 1'b0};
        vec[22] = '{3'b101, 32'hA5A5A5A5,  5'd3, 32'hA5A5A5A5, 1'b1};
        vec[23] = '{3'b111, 32'h0000FFFF, 5'd31, 32'h0000FFFF, 1'b1};
        vec[24] = '{SRA,    32'h40000000, 5'd30, 32'h00000001, 1'b0};

        a_rst_n = 1'b0; a_valid_i = 1'b0; a_ready_i = 1'b1;
        a_data_i = 32'h0; a_shift = 5'd0; a_op = SLL;
        b_rst_n = 1'b0; b_valid_i = 1'b0; b_ready_i = 1'b1;
        b_data_i = 16'h0; b_shift = 4'd0; b_op = SLL;

        // Reset held for two edges, then idle
        tick();
        tick();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        #1;
        check("reset valid_o", 32'(a_valid_o), 32'd0);
        check("reset data_o", a_data_o, 32'h0);
        check("reset op_err_o", 32'(a_op_err_o), 32'd0);
        check("reset ready_o", 32'(a_ready_o), 32'd1);
        check("reset B valid_o", 32'(b_valid_o), 32'd0);
        tick();
        check("idle valid_o", 32'(a_valid_o), 32'd0);

        // Modes back to back, then extremes, zero shifts and illegal ops
        run_vectors(0, 5);
        run_vectors(5, NVEC - 5);

        // Back-pressure: three in flight, stall for four cycles
        a_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_a(SLL, 32'h1, 5'(i + 1));
            tick();
        end
        drive_a(SLL, 32'h1, 5'd4);  // offered during the stall, must be ignored
        a_ready_i = 1'b0;
        #1;
        check("stall first valid", 32'(a_valid_o), 32'd1);
        check("stall first data", a_data_o, 32'h2);
        for (int s = 0; s < 4; s++) begin
            check("stall ready_o", 32'(a_ready_o), 32'd0);
            tick();
            check("stall valid_o", 32'(a_valid_o), 32'd1);
            check("stall data_o", a_data_o, 32'h2);
            check("stall op_err_o", 32'(a_op_err_o), 32'd0);
        end
        // ready_i rises together with a fresh transaction
        a_ready_i = 1'b1;
        drive_a(SLL, 32'h1, 5'd5);
        #1;
        check("release ready_o", 32'(a_ready_o), 32'd1);
        tick();
        a_valid_i = 1'b0;
        check("drain 1 valid", 32'(a_valid_o), 32'd1);
        check("drain 1 data", a_data_o, 32'h4);
        tick();
        check("drain 2 valid", 32'(a_valid_o), 32'd1);
        check("drain 2 data", a_data_o, 32'h8);
        tick();
        check("drain 3 valid", 32'(a_valid_o), 32'd1);
        check("drain 3 data", a_data_o, 32'h20);
        tick();
        check("drain empty", 32'(a_valid_o), 32'd0);

        // Reset mid-flight discards both transactions
        drive_a(3'b110, 32'hCAFEF00D, 5'd0);
        tick();
        drive_a(SRL, 32'hFFFF0000, 5'd4);
        tick();
        a_valid_i = 1'b0;
        a_rst_n   = 1'b0;
        tick();
        a_rst_n   = 1'b1;
        #1;
        check("midreset valid_o", 32'(a_valid_o), 32'd0);
        check("midreset data_o", a_data_o, 32'h0);
        check("midreset op_err_o", 32'(a_op_err_o), 32'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (a_valid_o) pulses++;
        end
        check("midreset no pulse", 32'(pulses), 32'd0);

        // 16-bit configuration against the reference model
        bd = '{16'h8001, 16'h1234, 16'hF00F, 16'h7FFF};
        bs = '{4'd0, 4'd1, 4'd5, 4'd15};
        for (int o = 0; o < 7; o++) begin
            for (int d = 0; d < 4; d++) begin
                for (int s = 0; s < 4; s++) begin
                    q_op.push_back(3'(o));
                    q_d.push_back(bd[d]);
                    q_sh.push_back(bs[s]);
                end
            end
        end
        nb = q_op.size();
        rx = 0;
        b_ready_i = 1'b1;
        for (int n = 0; n < nb + LAT_B + 1; n++) begin
            if (n < nb) begin
                b_valid_i = 1'b1;
                b_op      = q_op[n];
                b_data_i  = q_d[n];
                b_shift   = q_sh[n];
            end else begin
                b_valid_i = 1'b0;
            end
            tick();
            if (b_valid_o) begin
                if (rx < nb) begin
                    e = ref16(q_op[rx], q_d[rx], q_sh[rx]);
                    check($sformatf("B latency t%0d", rx), 32'(n), 32'(rx + LAT_B - 1));
                    check($sformatf("B data t%0d op%0d", rx, q_op[rx]), 32'(b_data_o), 32'(e[15:0]));
                    check($sformatf("B err t%0d", rx), 32'(b_op_err_o), 32'(e[16]));
                end else begin
                    check("B extra result", 32'(rx), 32'(nb - 1));
                end
                rx++;
            end
        end
        check("B result count", 32'(rx), 32'(nb));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
